// File: rtl/phrase_pkg.sv
// phrase_pkg: shared FSM state encoding and default widths for phrase_streamer
package phrase_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/phrase_streamer.sv
// phrase_streamer: streams a length-limited byte phrase from a read-only RAM
// Ports: clock/reset (sync, active-high); start/base_addr/max_len request a phrase;
// mem_addr/mem_q/mem_wren read the byte RAM (combinational read data);
// byte_data/byte_valid/byte_ready form the output handshake;
// busy, done (one-cycle pulse) and count (bytes accepted) report status.
// Define NUL_TERM_EN to end a phrase early on a 0x00 byte, which is not emitted.
module phrase_streamer
  import phrase_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] max_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              mem_wren,
  output logic [DATA_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, len_q, len_d, count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, done_q, done_d;
  assign mem_addr   = ptr_q;
  assign mem_wren   = 1'b0;
  assign byte_data  = data_q;
  assign byte_valid = valid_q;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign count      = count_q;
  // done is registered out of FIN, so it is seen in the first IDLE cycle;
  // start is held off during that cycle so a new phrase begins after done.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = state_q == FIN;
    case (state_q)
      IDLE: if (start && !done_q) begin
        ptr_d   = base_addr;
        len_d   = max_len;
        count_d = '0;
        state_d = (max_len == '0) ? FIN : FETCH;
      end
      FETCH: begin
`ifdef NUL_TERM_EN
        if (mem_q == '0) state_d = FIN;
        else begin
          data_d  = mem_q;
          valid_d = 1'b1;
          state_d = SEND;
        end
`else
        data_d  = mem_q;
        valid_d = 1'b1;
        state_d = SEND;
`endif
      end
      SEND: if (byte_ready) begin
        count_d = count_q + ADDR_W'(1);
        ptr_d   = ptr_q + ADDR_W'(1);
        valid_d = 1'b0;
        state_d = (count_q + ADDR_W'(1) == len_q) ? FIN : FETCH;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_phrase_streamer.sv
// tb_phrase_streamer: directed self-checking bench for phrase_streamer
module tb_phrase_streamer;
  logic clock = 1'b0;
  logic reset, start, byte_ready, mem_wren, byte_valid, busy, done;
  logic [7:0] base_addr, max_len, mem_addr, mem_q, byte_data, count;
  logic [7:0] ram [256];
  logic [7:0] got_d [$];
  logic [7:0] got_a [$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int dc;

  phrase_streamer dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .max_len(max_len), .mem_addr(mem_addr), .mem_q(mem_q), .mem_wren(mem_wren),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clock = ~clock;
  assign mem_q = ram[mem_addr];

  always @(posedge clock) begin
    if (!reset && byte_valid && byte_ready) begin
      got_d.push_back(byte_data);
      got_a.push_back(mem_addr);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [7:0] b, input logic [7:0] l);
    @(negedge clock);
    start = 1'b1;
    base_addr = b;
    max_len = l;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 80; i++) begin
      if (done) break;
      @(negedge clock);
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic chk_bytes(input string tag, input int n, input logic [7:0] b);
    chk({tag, "_nbytes"}, got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_d[i], ram[8'(b + i)]);
      chk($sformatf("%s_addr%0d", tag, i), got_a[i], 8'(b + i));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    byte_ready = 1'b1;
    base_addr = '0;
    max_len = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[8'h10] = 8'h41; ram[8'h11] = 8'h42; ram[8'h12] = 8'h43;
    ram[8'h20] = 8'h48; ram[8'h21] = 8'h49; ram[8'h22] = 8'h00; ram[8'h23] = 8'h58;
    for (int k = 0; k < 6; k++) ram[8'h24 + k] = 8'(8'h60 + k);
    repeat (3) @(negedge clock);
    chk("rst_valid", byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wren", mem_wren, 0);
    reset = 1'b0;

    got_d.delete(); got_a.delete();
    go(8'h10, 8'd3);
    chk("basic_lat1_valid", byte_valid, 0);
    chk("basic_busy", busy, 1);
    @(negedge clock);
    chk("basic_lat2_valid", byte_valid, 1);
    chk("basic_first", byte_data, 8'h41);
    start = 1'b1; base_addr = 8'h80; max_len = 8'd1;
    @(negedge clock);
    start = 1'b0;
    wait_done("basic");
    chk("basic_count", count, 3);
    chk_bytes("basic", 3, 8'h10);
    chk("basic_b2", got_d.size() > 1 ? got_d[1] : 8'hxx, 8'h42);
    @(negedge clock);
    chk("basic_done_width", done, 0);
    chk("basic_idle", busy, 0);
    chk("basic_count_hold", count, 3);

    got_d.delete(); got_a.delete();
    go(8'h10, 8'd3);
    @(negedge clock);
    chk("bp_first", byte_data, 8'h41);
    @(negedge clock);
    chk("bp_gap", byte_valid, 0);
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("bp_hold_valid%0d", i), byte_valid, 1);
      chk($sformatf("bp_hold_data%0d", i), byte_data, 8'h42);
    end
    byte_ready = 1'b1;
    wait_done("bp");
    chk("bp_count", count, 3);
    chk_bytes("bp", 3, 8'h10);

    got_d.delete(); got_a.delete();
    go(8'hFE, 8'd4);
    wait_done("wrap");
    chk("wrap_count", count, 4);
    chk_bytes("wrap", 4, 8'hFE);
    chk("wrap_a2", got_a.size() > 2 ? got_a[2] : 8'hxx, 8'h00);

    got_d.delete(); got_a.delete();
    go(8'h30, 8'd0);
    chk("zero_fin_busy", busy, 1);
    chk("zero_fin_nodone", done, 0);
    @(negedge clock);
    chk("zero_done", done, 1);
    chk("zero_idle", busy, 0);
    start = 1'b1; base_addr = 8'h30; max_len = 8'd5;
    @(negedge clock);
    start = 1'b0;
    chk("zero_start_ignored", busy, 0);
    chk("zero_done_off", done, 0);
    chk("zero_count", count, 0);
    chk("zero_nbytes", got_d.size(), 0);

    got_d.delete(); got_a.delete();
    go(8'h20, 8'd10);
    wait_done("nul");
`ifdef NUL_TERM_EN
    chk("nul_count", count, 2);
    chk_bytes("nul", 2, 8'h20);
`else
    chk("nul_count", count, 10);
    chk_bytes("nul", 10, 8'h20);
`endif

    byte_ready = 1'b0;
    go(8'h10, 8'd3);
    @(negedge clock);
    chk("rmid_valid", byte_valid, 1);
    dc = done_cnt;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rmid_valid_off", byte_valid, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_count", count, 0);
    byte_ready = 1'b1;
    repeat (4) @(negedge clock);
    chk("rmid_no_done", done_cnt, dc);
    got_d.delete(); got_a.delete();
    go(8'h10, 8'd3);
    wait_done("rmid_after");
    chk("rmid_after_count", count, 3);
    chk_bytes("rmid_after", 3, 8'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
